// File: rtl/sccb_target.sv
// SCCB responder: oversamples SIO_C/SIO_D, decodes 3-phase writes and 2-phase read
// transactions against an internal register file. Optional macro: SCCB_TARGET_AUTOINC_EN.
module sccb_target #(
    parameter logic [6:0] DEV_ID    = 7'h21,
    parameter int         REG_DEPTH = 16
) (
    input  logic       sccb_clk,
    input  logic       sccb_reset,
    input  logic       sio_c,
    input  logic       sio_d_in,
    output logic       sio_d_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    input  logic [7:0] reg_rd_addr,
    output logic [7:0] reg_rd_data
);

    typedef enum logic [3:0] {
        S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_NA, S_IGNORE
    } state_t;

    state_t     state_q;
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_hist_q, sda_hist_q;
    logic [2:0] bit_cnt_q;
    logic       byte_done_q;
    logic [7:0] shift_q, tx_q, ptr_q;
    logic       rw_q;
    logic [7:0] regs_q [REG_DEPTH];
    logic [7:0] rd_ptr_byte;

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  =  scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s &  scl_hist_q;
    assign start_det =  scl_s & scl_hist_q &  sda_hist_q & ~sda_s;
    assign stop_det  =  scl_s & scl_hist_q & ~sda_hist_q &  sda_s;

    // Out-of-range addresses match no entry and read as zero.
    function automatic logic [7:0] reg_lookup(input logic [7:0] addr);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < REG_DEPTH; i++)
            if (addr == 8'(i)) v = regs_q[i];
        return v;
    endfunction

    // NOTE: give every always_comb output a default first so no latch is inferred.
    always_comb begin
        rd_ptr_byte = 8'h00;
        rd_ptr_byte = reg_lookup(ptr_q);
    end

    // Synchronizers reset low so a released bus never looks like a START.
    always_ff @(posedge sccb_clk or posedge sccb_reset) begin
        if (sccb_reset) begin
            scl_sync_q <= 2'b00;
            sda_sync_q <= 2'b00;
            scl_hist_q <= 1'b0;
            sda_hist_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            scl_sync_q <= {scl_sync_q[0], sio_c};
            sda_sync_q <= {sda_sync_q[0], sio_d_in};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    always_ff @(posedge sccb_clk or posedge sccb_reset) begin
        if (sccb_reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            ptr_q       <= 8'h00;
            rw_q        <= 1'b0;
            sio_d_oe    <= 1'b0;
            busy        <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= 8'h00;
            wr_data     <= 8'h00;
            // NOTE: the register file is small and must read zero after reset, so it is reset explicitly.
            for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= 8'h00;
        end else begin
            wr_valid <= 1'b0;
            if (start_det) begin
                state_q     <= S_ID;
                bit_cnt_q   <= 3'd0;
                byte_done_q <= 1'b0;
                sio_d_oe    <= 1'b0;
                busy        <= 1'b1;
            end else if (stop_det) begin
                state_q  <= S_IDLE;
                sio_d_oe <= 1'b0;
                busy     <= 1'b0;
            end else begin
                unique case (state_q)
                    S_ID, S_SUB, S_WDATA: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) byte_done_q <= 1'b1;
                        end else if (scl_fall && byte_done_q) begin
                            byte_done_q <= 1'b0;
                            bit_cnt_q   <= 3'd0;
                            if (state_q == S_ID) begin
                                if (shift_q[7:1] == DEV_ID) begin
                                    sio_d_oe <= 1'b1;
                                    rw_q     <= shift_q[0];
                                    state_q  <= S_ID_ACK;
                                end else begin
                                    sio_d_oe <= 1'b0;
                                    state_q  <= S_IGNORE;
                                end
                            end else if (state_q == S_SUB) begin
                                ptr_q    <= shift_q;
                                sio_d_oe <= 1'b1;
                                state_q  <= S_SUB_ACK;
                            end else begin
                                sio_d_oe <= 1'b1;
                                state_q  <= S_WDATA_ACK;
                                wr_valid <= 1'b1;
                                wr_addr  <= ptr_q;
                                wr_data  <= shift_q;
                                for (int i = 0; i < REG_DEPTH; i++)
                                    if (ptr_q == 8'(i)) regs_q[i] <= shift_q;
`ifdef SCCB_TARGET_AUTOINC_EN
                                ptr_q <= ptr_q + 8'd1;
`endif
                            end
                        end
                    end
                    S_ID_ACK: begin
                        if (scl_fall) begin
                            if (rw_q) begin
                                sio_d_oe  <= ~rd_ptr_byte[7];
                                tx_q      <= {rd_ptr_byte[6:0], 1'b0};
                                bit_cnt_q <= 3'd1;
                                state_q   <= S_RDATA;
                            end else begin
                                sio_d_oe <= 1'b0;
                                state_q  <= S_SUB;
                            end
                        end
                    end
                    S_SUB_ACK, S_WDATA_ACK: begin
                        if (scl_fall) begin
                            sio_d_oe <= 1'b0;
                            state_q  <= S_WDATA;
                        end
                    end
                    // bit_cnt_q counts bits already driven; wrap to 0 means all 8 are out.
                    S_RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt_q != 3'd0) begin
                                sio_d_oe  <= ~tx_q[7];
                                tx_q      <= {tx_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end else begin
                                sio_d_oe    <= 1'b0;
                                byte_done_q <= 1'b0;
                                state_q     <= S_RDATA_NA;
                            end
                        end
                    end
                    S_RDATA_NA: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state_q <= S_IGNORE;
                            end else begin
                                byte_done_q <= 1'b1;
`ifdef SCCB_TARGET_AUTOINC_EN
                                ptr_q <= ptr_q + 8'd1;
`endif
                            end
                        end else if (scl_fall && byte_done_q) begin
                            sio_d_oe    <= ~rd_ptr_byte[7];
                            tx_q        <= {rd_ptr_byte[6:0], 1'b0};
                            bit_cnt_q   <= 3'd1;
                            byte_done_q <= 1'b0;
                            state_q     <= S_RDATA;
                        end
                    end
                    default: sio_d_oe <= 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge sccb_clk or posedge sccb_reset) begin
        if (sccb_reset) reg_rd_data <= 8'h00;
        else            reg_rd_data <= reg_lookup(reg_rd_addr);
    end

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: bit-banged SCCB master on an open-drain SIO_D model.
module tb_sccb_target;

    localparam time Q = 100ns;

    logic       sccb_clk = 1'b0;
    logic       sccb_reset;
    logic       sio_c;
    logic       sda_m;
    logic       sio_d_in;
    logic       sio_d_oe;
    logic       wr_valid;
    logic [7:0] wr_addr, wr_data;
    logic       busy;
    logic [7:0] reg_rd_addr;
    logic [7:0] reg_rd_data;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int oe_cycles = 0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_data = 8'h00;

    assign sio_d_in = sda_m & ~sio_d_oe;

    sccb_target #(.DEV_ID(7'h21), .REG_DEPTH(16)) dut (
        .sccb_clk    (sccb_clk),
        .sccb_reset  (sccb_reset),
        .sio_c       (sio_c),
        .sio_d_in    (sio_d_in),
        .sio_d_oe    (sio_d_oe),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data)
    );

    always #5ns sccb_clk = ~sccb_clk;

    always @(negedge sccb_clk) begin
        if (wr_valid) begin
            wr_count  = wr_count + 1;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (sio_d_oe) oe_cycles = oe_cycles + 1;
    end

    task automatic bus_start();
        sda_m = 1'b1; sio_c = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        sio_c = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        sio_c = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #Q;
        sio_c = 1'b1; #(2*Q);
        sio_c = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q;
        sio_c = 1'b1; #Q;
        b = sio_d_in; #Q;
        sio_c = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
    endtask

    task automatic read_local(input logic [7:0] addr, output logic [7:0] d);
        @(negedge sccb_clk);
        reg_rd_addr = addr;
        @(posedge sccb_clk);
        #1;
        d = reg_rd_data;
    endtask

    task automatic test_reset();
        checks++; if (sio_d_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", sio_d_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
        checks++; if (reg_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", reg_rd_data); end
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        logic [7:0] d;
        int wc;
        wc = wr_count;
        bus_start();
        write_byte(8'h42, a0);
        write_byte(8'h05, a1);
        write_byte(8'hA5, a2);
        bus_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL write_acks: got %b want 000", {a0, a1, a2}); end
        checks++; if (wr_count - wc !== 1) begin errors++; $display("FAIL write_pulses: got %0d want 1", wr_count - wc); end
        checks++; if (last_addr !== 8'h05) begin errors++; $display("FAIL write_addr: got %h want 05", last_addr); end
        checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL write_data: got %h want a5", last_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
        read_local(8'h05, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL write_local_read: got %h want a5", d); end
    endtask

    task automatic test_read();
        logic a0, a1, a2, oe_na;
        logic [7:0] d;
        bus_start();
        write_byte(8'h42, a0);
        write_byte(8'h05, a1);
        bus_stop();
        bus_start();
        write_byte(8'h43, a2);
        read_byte(d);
        // master NA bit, with the target's drive sampled while SCL is high
        sda_m = 1'b1; #Q;
        sio_c = 1'b1; #Q;
        oe_na = sio_d_oe; #Q;
        sio_c = 1'b0; #Q;
        bus_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL read_acks: got %b want 000", {a0, a1, a2}); end
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL read_data: got %h want a5", d); end
        checks++; if (oe_na !== 1'b0) begin errors++; $display("FAIL read_oe_during_na: got %b want 0", oe_na); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_wrong_id();
        logic a0, a1, a2;
        logic [7:0] d;
        int wc, oc;
        wc = wr_count;
        oc = oe_cycles;
        bus_start();
        write_byte(8'h60, a0);
        write_byte(8'h05, a1);
        write_byte(8'h11, a2);
        bus_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL wrong_id_acks: got %b want 111", {a0, a1, a2}); end
        checks++; if (oe_cycles - oc !== 0) begin errors++; $display("FAIL wrong_id_oe_cycles: got %0d want 0", oe_cycles - oc); end
        checks++; if (wr_count - wc !== 0) begin errors++; $display("FAIL wrong_id_pulses: got %0d want 0", wr_count - wc); end
        read_local(8'h05, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL wrong_id_reg5: got %h want a5", d); end
    endtask

    task automatic test_out_of_range();
        logic a0, a1, a2, a3, a4, a5, na;
        logic [7:0] d, dl;
        int wc;
        wc = wr_count;
        bus_start();
        write_byte(8'h42, a0);
        write_byte(8'h20, a1);
        write_byte(8'h77, a2);
        bus_stop();
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL oor_acks: got %b want 000", {a0, a1, a2}); end
        checks++; if (wr_count - wc !== 1) begin errors++; $display("FAIL oor_pulses: got %0d want 1", wr_count - wc); end
        checks++; if (last_addr !== 8'h20) begin errors++; $display("FAIL oor_addr: got %h want 20", last_addr); end
        checks++; if (last_data !== 8'h77) begin errors++; $display("FAIL oor_data: got %h want 77", last_data); end
        bus_start();
        write_byte(8'h42, a3);
        write_byte(8'h20, a4);
        bus_stop();
        bus_start();
        write_byte(8'h43, a5);
        read_byte(d);
        write_bit(1'b1);
        bus_stop();
        na = a3 | a4 | a5;
        checks++; if ({na, d} !== 9'h000) begin errors++; $display("FAIL oor_bus_read: got ack_or=%b data=%h want 0/00", na, d); end
        read_local(8'h20, dl);
        checks++; if (dl !== 8'h00) begin errors++; $display("FAIL oor_local_read: got %h want 00", dl); end
    endtask

    task automatic test_back_to_back();
        logic a0, a1, a2, a3;
        logic [7:0] d;
        int wc;
        wc = wr_count;
        bus_start();
        write_byte(8'h42, a0);
        write_byte(8'h0F, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        bus_stop();
        read_local(8'h0F, d);
        checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL b2b_acks: got %b want 0000", {a0, a1, a2, a3}); end
        checks++; if (wr_count - wc !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", wr_count - wc); end
`ifdef SCCB_TARGET_AUTOINC_EN
        checks++; if (last_addr !== 8'h10) begin errors++; $display("FAIL b2b_last_addr: got %h want 10", last_addr); end
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL b2b_reg15: got %h want 11", d); end
`else
        checks++; if (last_addr !== 8'h0F) begin errors++; $display("FAIL b2b_last_addr: got %h want 0f", last_addr); end
        checks++; if (d !== 8'h22) begin errors++; $display("FAIL b2b_reg15: got %h want 22", d); end
`endif
    endtask

    task automatic test_reset_mid();
        logic a0, a1, a2, a3, a4;
        logic [7:0] d;
        logic [7:0] v;
        int wc;
        bus_start();
        write_byte(8'h42, a0);
        write_byte(8'h05, a1);
        v = 8'hC3;
        for (int i = 7; i >= 4; i--) write_bit(v[i]);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before_reset: got %b want 1", busy); end
        sccb_reset = 1'b1;
        #1;
        checks++; if ({sio_d_oe, busy} !== 2'b00) begin errors++; $display("FAIL mid_reset_oe_busy: got %b want 00", {sio_d_oe, busy}); end
        sda_m = 1'b1; #Q;
        sio_c = 1'b1; #Q;
        @(negedge sccb_clk);
        sccb_reset = 1'b0;
        #Q;
        read_local(8'h05, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL mid_reg5_cleared: got %h want 00", d); end
        wc = wr_count;
        bus_start();
        write_byte(8'h42, a2);
        write_byte(8'h07, a3);
        write_byte(8'hC3, a4);
        bus_stop();
        checks++; if ({a2, a3, a4} !== 3'b000) begin errors++; $display("FAIL mid_after_acks: got %b want 000", {a2, a3, a4}); end
        checks++; if (wr_count - wc !== 1) begin errors++; $display("FAIL mid_after_pulses: got %0d want 1", wr_count - wc); end
        checks++; if ({last_addr, last_data} !== 16'h07C3) begin errors++; $display("FAIL mid_after_commit: got %h want 07c3", {last_addr, last_data}); end
        read_local(8'h07, d);
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL mid_after_reg7: got %h want c3", d); end
    endtask

    initial begin
        sccb_reset  = 1'b1;
        sio_c       = 1'b1;
        sda_m       = 1'b1;
        reg_rd_addr = 8'h05;
        #50ns;
        test_reset();
        @(negedge sccb_clk);
        sccb_reset = 1'b0;
        #Q;
        test_write();
        test_read();
        test_wrong_id();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
